// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache with one outstanding line fill (IDLE/REQ/WAIT).
// Define ICACHE_STATS_EN to add saturating HitCount/MissCount outputs.
module icache #(
  parameter int unsigned WORD_SIZE  = 32,
  parameter int unsigned NUM_LINES  = 4,
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [WORD_SIZE-1:0]            PC,
  input  logic                            Fetch,
  output logic [WORD_SIZE-1:0]            Instr,
  output logic                            Stall,
  output logic                            MemRead,
  output logic [WORD_SIZE-1:0]            MemPC,
  input  logic                            MemReady,
  input  logic [LINE_WORDS*WORD_SIZE-1:0] MemLine
`ifdef ICACHE_STATS_EN
  ,
  output logic [15:0]                     HitCount,
  output logic [15:0]                     MissCount
`endif
);

  localparam int unsigned BYTE_W  = $clog2(WORD_SIZE / 8);
  localparam int unsigned OFF_W   = $clog2(LINE_WORDS);
  localparam int unsigned IDX_W   = $clog2(NUM_LINES);
  localparam int unsigned IDX_LSB = BYTE_W + OFF_W;
  localparam int unsigned TAG_LSB = IDX_LSB + IDX_W;
  localparam int unsigned TAG_W   = WORD_SIZE - TAG_LSB;
  localparam int unsigned LINE_W  = LINE_WORDS * WORD_SIZE;
  localparam int unsigned LADDR_W = WORD_SIZE - IDX_LSB;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [NUM_LINES-1:0] valid_q, valid_d;
  logic [LADDR_W-1:0]   miss_line_q, miss_line_d;
  logic                 mem_read_q, mem_read_d;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [LINE_W-1:0]    data_q [NUM_LINES];

  logic [OFF_W-1:0]     pc_off;
  logic [IDX_W-1:0]     pc_idx;
  logic [TAG_W-1:0]     pc_tag;
  logic [IDX_W-1:0]     miss_idx;
  logic [TAG_W-1:0]     miss_tag;
  logic [LINE_W-1:0]    line_rd;
  logic                 hit;
  logic                 miss;
  logic                 fill_we;
  logic                 unused_pc_byte;

  assign pc_off         = PC[IDX_LSB-1:BYTE_W];
  assign pc_idx         = PC[TAG_LSB-1:IDX_LSB];
  assign pc_tag         = PC[WORD_SIZE-1:TAG_LSB];
  assign miss_idx       = miss_line_q[IDX_W-1:0];
  assign miss_tag       = miss_line_q[LADDR_W-1:IDX_W];
  assign unused_pc_byte = ^PC[BYTE_W-1:0];
  assign MemRead        = mem_read_q;
  assign MemPC          = {miss_line_q, {IDX_LSB{1'b0}}};

  // Zero-latency lookup; only meaningful in IDLE
  always_comb begin
    line_rd = data_q[pc_idx];
    hit     = Fetch && valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag) && (state_q == S_IDLE);
    miss    = Fetch && !hit && (state_q == S_IDLE);
    Instr   = line_rd[WORD_SIZE-1:0];
    for (int unsigned w = 0; w < LINE_WORDS; w++) begin
      if (pc_off == OFF_W'(w)) Instr = line_rd[w*WORD_SIZE +: WORD_SIZE];
    end
  end

  // Fill sequencer; REQ only advances once a stale MemReady has dropped
  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    miss_line_d = miss_line_q;
    fill_we     = 1'b0;
    Stall       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        Stall = miss;
        if (miss) begin
          state_d     = S_REQ;
          miss_line_d = PC[WORD_SIZE-1:IDX_LSB];
        end
      end
      S_REQ: begin
        Stall = 1'b1;
        if (!MemReady) state_d = S_WAIT;
      end
      S_WAIT: begin
        Stall = 1'b1;
        if (MemReady) begin
          fill_we           = 1'b1;
          valid_d[miss_idx] = 1'b1;
          state_d           = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    mem_read_d = (state_d == S_REQ);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      valid_q     <= '0;
      miss_line_q <= '0;
      mem_read_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      miss_line_q <= miss_line_d;
      mem_read_q  <= mem_read_d;
    end
  end

  // Tag/data arrays are not reset; the valid bits alone qualify them
  always_ff @(posedge clk) begin
    if (fill_we) begin
      tag_q[miss_idx]  <= miss_tag;
      data_q[miss_idx] <= MemLine;
    end
  end

`ifdef ICACHE_STATS_EN
  logic [15:0] hit_cnt_q, hit_cnt_d;
  logic [15:0] miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (hit && (hit_cnt_q != 16'hFFFF))   hit_cnt_d  = hit_cnt_q + 16'd1;
    if (miss && (miss_cnt_q != 16'hFFFF)) miss_cnt_d = miss_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign HitCount  = hit_cnt_q;
  assign MissCount = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache.sv
// Scoreboard bench for icache: fetches push expected words, a forked monitor checks served Instr.
module tb_icache;
  localparam int unsigned WS     = 32;
  localparam int unsigned LINE_W = 128;
  localparam int          LAT    = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [WS-1:0]     PC = '0;
  logic              Fetch = 1'b0;
  logic [WS-1:0]     Instr;
  logic              Stall;
  logic              MemRead;
  logic [WS-1:0]     MemPC;
  logic              MemReady;
  logic [LINE_W-1:0] MemLine;
`ifdef ICACHE_STATS_EN
  logic [15:0]       HitCount;
  logic [15:0]       MissCount;
`endif

  int            n_checks = 0;
  int            n_fail   = 0;
  logic [WS-1:0] exp_q[$];
  bit            sb_en = 1'b1;

  icache #(.WORD_SIZE(32), .NUM_LINES(4), .LINE_WORDS(4)) dut (
    .clk(clk), .rst(rst), .PC(PC), .Fetch(Fetch), .Instr(Instr), .Stall(Stall),
    .MemRead(MemRead), .MemPC(MemPC), .MemReady(MemReady), .MemLine(MemLine)
`ifdef ICACHE_STATS_EN
    , .HitCount(HitCount), .MissCount(MissCount)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [WS-1:0] word_at(input logic [WS-1:0] a);
    return 32'hC0DE_0000 | {16'h0, a[15:0]};
  endfunction

  // Memory: notes a request, drops Ready one cycle later, raises Ready with data after LAT cycles
  typedef enum logic [1:0] {M_IDLE, M_SEEN, M_BUSY} mstate_e;
  mstate_e       m_state;
  logic [WS-1:0] m_addr;
  int            m_cnt;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_state  <= M_IDLE;
      m_addr   <= '0;
      m_cnt    <= 0;
      MemReady <= 1'b0;
      MemLine  <= '0;
    end else begin
      case (m_state)
        M_IDLE: if (MemRead) begin
          m_state <= M_SEEN;
          m_addr  <= MemPC;
        end
        M_SEEN: begin
          MemReady <= 1'b0;
          m_cnt    <= LAT - 1;
          m_state  <= M_BUSY;
        end
        default: begin
          if (m_cnt == 0) begin
            MemReady <= 1'b1;
            for (int w = 0; w < 4; w++) MemLine[w*32 +: 32] <= word_at(m_addr + 32'(4 * w));
            m_state <= M_IDLE;
          end else begin
            m_cnt <= m_cnt - 1;
          end
        end
      endcase
    end
  end

  task automatic check(input string name, input logic [WS-1:0] act, input logic [WS-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (sb_en && rst && Fetch && !Stall) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_instr@%08h: got 0x%08h with no expected entry", PC, Instr);
        end else begin
          check($sformatf("instr@%08h", PC), Instr, exp_q.pop_front());
        end
      end
    end
  endtask

  // Issue one fetch and wait for service; optionally move PC to pc_sw after sw_at stall cycles
  task automatic fetch(input logic [WS-1:0] pc, input logic [WS-1:0] exp_instr,
                       input int exp_stalls, input logic [WS-1:0] exp_mempc = '0,
                       input logic [WS-1:0] pc_sw = '0, input int sw_at = 0);
    int            stalls = 0;
    int            reads  = 0;
    logic [WS-1:0] seen_pc = '0;
    bit            served = 1'b0;
    @(posedge clk); #1;
    PC    = pc;
    Fetch = 1'b1;
    exp_q.push_back(exp_instr);
    for (int i = 0; i < 60 && !served; i++) begin
      @(negedge clk);
      if (MemRead) begin
        reads++;
        seen_pc = MemPC;
      end
      if (Stall) begin
        stalls++;
        if (stalls == sw_at) begin
          @(posedge clk); #1;
          PC = pc_sw;
        end
      end else begin
        served = 1'b1;
      end
    end
    if (!served) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout@%08h: still stalled after 60 cycles, required service", pc);
      exp_q.delete();
    end
    check($sformatf("stalls@%08h", pc), 32'(stalls), 32'(exp_stalls));
    if (exp_stalls > 0) check($sformatf("mempc@%08h", pc), seen_pc, exp_mempc);
    else                check($sformatf("memread@%08h", pc), 32'(reads), 32'd0);
  endtask

  initial begin
    fork monitor(); join_none

    #3;
    check("rst_stall", {31'b0, Stall}, 32'd0);
    check("rst_memread", {31'b0, MemRead}, 32'd0);
    check("rst_mempc", MemPC, 32'd0);
    #9 rst = 1'b1;

    fetch(32'h10, 32'hC0DE_0010, 7, 32'h10);
    fetch(32'h14, 32'hC0DE_0014, 0);
    fetch(32'h18, 32'hC0DE_0018, 0);
    fetch(32'h1C, 32'hC0DE_001C, 0);

    // Idle fetch on a missing address must not stall or start a fill
    @(posedge clk); #1;
    Fetch = 1'b0;
    PC    = 32'h70;
    @(negedge clk);
    check("nofetch_stall", {31'b0, Stall}, 32'd0);
    @(negedge clk);
    check("nofetch_memread", {31'b0, MemRead}, 32'd0);

    fetch(32'h50, 32'hC0DE_0050, 7, 32'h50);
    fetch(32'h10, 32'hC0DE_0010, 7, 32'h10);
    fetch(32'h24, 32'hC0DE_0024, 7, 32'h20);
    fetch(32'h1C, 32'hC0DE_001C, 0);
    fetch(32'h28, 32'hC0DE_0028, 0);
    fetch(32'h30, 32'hC0DE_0018, 7, 32'h30, 32'h18, 2);
    fetch(32'h30, 32'hC0DE_0030, 0);
    fetch(32'h3C, 32'hC0DE_003C, 0);

    // Reset while waiting on memory
    @(posedge clk); #1;
    PC    = 32'h90;
    Fetch = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (MemRead) break;
    end
    for (int i = 0; i < 30; i++) begin
      if (!MemRead && Stall) break;
      @(negedge clk);
    end
    check("wait_stall", {31'b0, Stall}, 32'd1);
    check("wait_memread", {31'b0, MemRead}, 32'd0);
    #2;
    rst   = 1'b0;
    Fetch = 1'b0;
    #1;
    check("midfill_rst_stall", {31'b0, Stall}, 32'd0);
    check("midfill_rst_memread", {31'b0, MemRead}, 32'd0);
    check("midfill_rst_mempc", MemPC, 32'd0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;

    fetch(32'h10, 32'hC0DE_0010, 7, 32'h10);
    fetch(32'h24, 32'hC0DE_0024, 7, 32'h20);
    fetch(32'h14, 32'hC0DE_0014, 0);

`ifdef ICACHE_STATS_EN
    @(posedge clk); #1;
    Fetch = 1'b0;
    @(negedge clk); #2;
    rst = 1'b0;
    #1;
    check("stats_rst_hit", {16'h0, HitCount}, 32'd0);
    #5 rst = 1'b1;
    fetch(32'h10, 32'hC0DE_0010, 7, 32'h10);
    fetch(32'h14, 32'hC0DE_0014, 0);
    fetch(32'h18, 32'hC0DE_0018, 0);
    @(posedge clk); #1;
    Fetch = 1'b0;
    @(negedge clk);
    check("stats_miss", {16'h0, MissCount}, 32'd1);
    check("stats_hit", {16'h0, HitCount}, 32'd3);
    sb_en = 1'b0;
    @(posedge clk); #1;
    PC    = 32'h14;
    Fetch = 1'b1;
    repeat (65536) @(posedge clk);
    #1;
    Fetch = 1'b0;
    @(negedge clk);
    sb_en = 1'b1;
    check("stats_hit_sat", {16'h0, HitCount}, 32'h0000_FFFF);
    check("stats_miss_hold", {16'h0, MissCount}, 32'd1);
`endif

    @(posedge clk); #1;
    Fetch = 1'b0;
    @(negedge clk);
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
